// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, flush, and an optional
// two-entry skid buffer so in_ready comes straight from a flop.
module pipe_stage_reg #(
  parameter int DATA_W          = 90,
  parameter bit SKID            = 1'b1,
  parameter bit CLEAR_ON_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  logic              main_valid, skid_valid, ready_q;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [1:0]        occ;

  logic              main_valid_n, skid_valid_n;
  logic [DATA_W-1:0] main_data_n, skid_data_n;
  logic              fire_in, main_free;

  assign main_free = !main_valid || out_ready;
  assign in_ready  = SKID ? ready_q : main_free;
  assign fire_in   = in_valid && in_ready;

  // fire_in never coincides with skid_valid: in_ready is !skid_valid in that mode
  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (main_free) begin
      if (skid_valid) begin
        main_valid_n = 1'b1;
        main_data_n  = skid_data;
        skid_valid_n = 1'b0;
        if (CLEAR_ON_BUBBLE) skid_data_n = '0;
      end else if (fire_in) begin
        main_valid_n = 1'b1;
        main_data_n  = in_data;
      end else begin
        main_valid_n = 1'b0;
        if (CLEAR_ON_BUBBLE) main_data_n = '0;
      end
    end else if (fire_in && SKID) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      occ        <= 2'd0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      occ        <= 2'd0;
      if (CLEAR_ON_BUBBLE) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      main_data  <= main_data_n;
      skid_data  <= skid_data_n;
      ready_q    <= !skid_valid_n;
      occ        <= 2'(main_valid_n) + 2'(skid_valid_n);
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=1 and a SKID=0 instance with the same stimulus; each is checked
// against its own queue of held payloads.
module tb_pipe_stage_reg;
  localparam int W = 90;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, flush;
  logic [W-1:0] in_data;
  logic         rdy1, vld1, rdy0, vld0;
  logic [W-1:0] dat1, dat0;
  logic [1:0]   occ1, occ0;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;
  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(W), .SKID(1'b1), .CLEAR_ON_BUBBLE(1'b1)) u_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(vld1), .out_ready(out_ready), .out_data(dat1), .flush(flush), .occupancy(occ1));

  pipe_stage_reg #(.DATA_W(W), .SKID(1'b0), .CLEAR_ON_BUBBLE(1'b1)) u_flat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .out_valid(vld0), .out_ready(out_ready), .out_data(dat0), .flush(flush), .occupancy(occ0));

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive, check current outputs against the model, advance the model, clock.
  task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy,
                     input logic fl, input logic r);
    logic e_rdy1, e_rdy0;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; rst = r;
    #1;
    e_rdy1 = (q1.size() < 2);
    e_rdy0 = (q0.size() == 0) || ordy;
    if (chk_en) begin
      chk("skid.in_ready",  W'(rdy1), W'(e_rdy1));
      chk("skid.out_valid", W'(vld1), W'(q1.size() != 0));
      chk("skid.occupancy", W'(occ1), W'(q1.size()));
      chk("skid.out_data",  dat1, (q1.size() != 0) ? q1[0] : '0);
      chk("flat.in_ready",  W'(rdy0), W'(e_rdy0));
      chk("flat.out_valid", W'(vld0), W'(q0.size() != 0));
      chk("flat.occupancy", W'(occ0), W'(q0.size()));
      chk("flat.out_data",  dat0, (q0.size() != 0) ? q0[0] : '0);
    end
    if (r || fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() != 0 && ordy) void'(q1.pop_front());
      if (iv && e_rdy1) q1.push_back(d);
      if (q0.size() != 0 && ordy) void'(q0.pop_front());
      if (iv && e_rdy0) q0.push_back(d);
    end
    @(posedge clk);
    #1;
    chk_en = 1'b1;
  endtask

  initial begin
    logic [W-1:0] ones;
    ones = '1;
    // reset held two cycles with a live upstream
    cyc(1'b1, ones, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, ones, 1'b1, 1'b0, 1'b1);
    // streaming 1..8
    for (int i = 1; i <= 8; i++) cyc(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // back-pressure: A, B, C with out_ready low, C kept offered
    cyc(1'b1, W'(8'h11), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, W'(8'h22), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, W'(8'h33), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, W'(8'h33), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, W'(8'h33), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // flush with two held and a live 0x44
    cyc(1'b1, W'(8'hAA), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, W'(8'hBB), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, W'(8'h44), 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // simultaneous in/out with one held
    cyc(1'b1, W'(8'h55), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, W'(8'h66), 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // random traffic with occasional flush and one mid-stream reset
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] d;
      d = {$urandom, $urandom, $urandom};
      cyc(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0),
          ($urandom_range(0, 40) == 0), (i == 200));
    end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
